// File: rtl/issue_prf_wbarb.sv
// rtl/issue_prf_wbarb.sv - round-robin writeback arbiter onto one PRF write port with ready scoreboard
module issue_prf_wbarb #(
  parameter int AW = 6,
  parameter int DW = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        wb_valid,
  input  logic [3*AW-1:0]   wb_addr,
  input  logic [3*DW-1:0]   wb_data,
  output logic [2:0]        wb_ready,
  output logic [AW-1:0]     prf_addra,
  output logic              prf_wea,
  output logic [DW-1:0]     prf_dina,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic [AW-1:0]     qry_addrb,
  output logic              qry_rdyb,
  input  logic [AW-1:0]     qry_addrc,
  output logic              qry_rdyc
);

  logic [1:0]        rr_ptr;
  logic [2:0]        cand;
  logic              gnt_any;
  logic [1:0]        gnt_idx;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_data;
  logic [2**AW-1:0]  rdy;

  // Scan requesters starting at rr_ptr; cand is wide enough to hold rr_ptr+2 before the mod-3 fold.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!gnt_any && wb_valid[cand[1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[1:0];
      end
    end
  end

  always_comb begin
    wb_ready = 3'b000;
    if (gnt_any && !reset) wb_ready = 3'b001 << gnt_idx;
  end

  assign sel_addr = wb_addr[int'(gnt_idx)*AW +: AW];
  assign sel_data = wb_data[int'(gnt_idx)*DW +: DW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= 2'd0;
      prf_wea   <= 1'b0;
      prf_addra <= '0;
      prf_dina  <= '0;
    end else begin
      prf_wea <= gnt_any;
      if (gnt_any) begin
        prf_addra <= sel_addr;
        prf_dina  <= sel_data;
        rr_ptr    <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      end
    end
  end

  // The alloc clear is written last so it overrides a same-address writeback set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy <= '1;
    end else begin
      if (prf_wea)  rdy[prf_addra]  <= 1'b1;
      if (alloc_en) rdy[alloc_addr] <= 1'b0;
    end
  end

  assign qry_rdyb = rdy[qry_addrb];
  assign qry_rdyc = rdy[qry_addrc];

endmodule
